// File: rtl/multicycle_decoder_pkg.sv
// ============================================================================
// Module      : multicycle_decoder_pkg
// Description : Shared types for the multi-cycle accumulator-CPU control unit:
//               opcode and state enums, ACC source select codes and the
//               branch condition evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_decoder_pkg;

  // Base opcode map; every code above JMP is illegal
  typedef enum logic [4:0] {
    HLT  = 5'd0,
    LDI  = 5'd1,
    ADDI = 5'd2,
    SUBI = 5'd3,
    LD   = 5'd4,
    ADD  = 5'd5,
    SUB  = 5'd6,
    STO  = 5'd7,
    BEQ  = 5'd8,
    BNE  = 5'd9,
    BGT  = 5'd10,
    BGE  = 5'd11,
    BLT  = 5'd12,
    BLE  = 5'd13,
    JMP  = 5'd14
  } opcode_t;

  localparam logic [4:0] C_OP_LAST_LEGAL = 5'b01110;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [1:0] SEL_A_ALU = 2'b00;
  localparam logic [1:0] SEL_A_MEM = 2'b01;
  localparam logic [1:0] SEL_A_IMM = 2'b10;

  // Branch condition from the Z/N flags; non-branch opcodes never take
  function automatic logic branch_taken(input opcode_t op, input logic z, input logic n);
    logic taken;
    taken = 1'b0;
    case (op)
      BEQ:     taken = z;
      BNE:     taken = !z;
      BGT:     taken = !z && !n;
      BGE:     taken = !n;
      BLT:     taken = n;
      BLE:     taken = z || n;
      JMP:     taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Opcodes that perform a data memory handshake in EXECUTE
  function automatic logic is_mem_op(input opcode_t op);
    return (op == LD) || (op == ADD) || (op == SUB) || (op == STO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_decoder_mem_wait_timer.sv
// ============================================================================
// Module      : mem_wait_timer
// Description : Wait-state counter shared by the instruction and data memory
//               ports. Counts cycles with a pending request and no ready,
//               clears on completion or when no request is pending, and flags
//               a timeout on the last permitted wait cycle.
//               TIMEOUT_CYCLES = 0 disables the timeout entirely.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_ready,
  output logic o_timeout
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer_en
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;
      logic          w_waiting;

      // Count stalled request cycles; any non-stalled cycle restarts the count
      always_comb begin
        w_waiting = i_req && !i_ready;
        count_d   = '0;
        if (w_waiting) begin
          count_d = count_q + CW'(1);
        end
      end

      // Wait counter register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign o_timeout = w_waiting && (count_q == C_LAST);
    end else begin : g_timer_dis
      assign o_timeout = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_decoder.sv
// ============================================================================
// Module      : multicycle_decoder
// Description : Multi-cycle control unit for the accumulator CPU. Sequences
//               FETCH/DECODE/EXECUTE/HALT, drives all datapath enables and
//               muxes, and handshakes with instruction and data memory under
//               a shared wait-state timeout.
//               Build option: DECODER_ILLEGAL_TRAP_EN - when defined, an
//               illegal opcode halts the core and sets illegal_out; otherwise
//               it executes as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_decoder
  import multicycle_decoder_pkg::*;
#(
  parameter int OPCODE_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic                    status_Z_in,
  input  logic                    status_N_in,
  input  logic                    imem_ready_in,
  input  logic                    dmem_ready_in,
  output logic                    imem_req_out,
  output logic                    dmem_req_out,
  output logic                    ir_wr_out,
  output logic                    acc_wr_out,
  output logic                    pc_wr_out,
  output logic                    status_wr_out,
  output logic                    data_memory_wr_out,
  output logic                    branch_out,
  output logic [1:0]              sel_A_out,
  output logic                    sel_B_out,
  output logic                    alu_op_out,
  output logic                    acc_reset_out,
  output logic                    pc_reset_out,
  output logic                    status_reset_out,
  output logic                    ir_reset_out,
  output logic                    halted_out,
  output logic                    bus_error_out,
  output logic                    illegal_out
);

  localparam logic [OPCODE_WIDTH-1:0] C_LAST_LEGAL = OPCODE_WIDTH'(C_OP_LAST_LEGAL);

  state_t  state_q;
  state_t  state_d;
  logic    bus_error_q;
  logic    bus_error_d;
  logic    w_legal;
  opcode_t w_op;
  logic    w_mem_req;
  logic    w_mem_ready;
  logic    w_timeout;

  // Upper opcode bits only matter for legality; the low five bits select the op
  assign w_legal = (op_code <= C_LAST_LEGAL);
  assign w_op    = opcode_t'(op_code[4:0]);

  // Datapath register resets follow the controller reset directly
  assign acc_reset_out    = reset_in;
  assign pc_reset_out     = reset_in;
  assign status_reset_out = reset_in;
  assign ir_reset_out     = reset_in;

  // One timer serves both ports: at most one request is active at a time
  assign w_mem_req   = imem_req_out || dmem_req_out;
  assign w_mem_ready = imem_req_out ? imem_ready_in : dmem_ready_in;

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_mem_wait_timer (
    .clk       (clock_in),
    .rst       (reset_in),
    .i_req     (w_mem_req),
    .i_ready   (w_mem_ready),
    .o_timeout (w_timeout)
  );

  // State register
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a ready that arrives in the timeout cycle still completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (imem_ready_in) begin
          state_d = DECODE;
        end else if (w_timeout) begin
          state_d = HALT;
        end
      end
      DECODE: begin
        if (!w_legal) begin
`ifdef DECODER_ILLEGAL_TRAP_EN
          state_d = HALT;
`else
          state_d = EXECUTE;
`endif
        end else if (w_op == HLT) begin
          state_d = HALT;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        if (w_legal && is_mem_op(w_op)) begin
          if (dmem_ready_in) begin
            state_d = FETCH;
          end else if (w_timeout) begin
            state_d = HALT;
          end
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end

  // Output decode; everything is forced inactive while reset is asserted
  always_comb begin
    imem_req_out       = 1'b0;
    dmem_req_out       = 1'b0;
    ir_wr_out          = 1'b0;
    acc_wr_out         = 1'b0;
    pc_wr_out          = 1'b0;
    status_wr_out      = 1'b0;
    data_memory_wr_out = 1'b0;
    branch_out         = 1'b0;
    sel_A_out          = SEL_A_ALU;
    sel_B_out          = 1'b0;
    alu_op_out         = 1'b0;
    if (!reset_in) begin
      case (state_q)
        FETCH: begin
          imem_req_out = 1'b1;
          ir_wr_out    = imem_ready_in;
        end
        EXECUTE: begin
          if (!w_legal) begin
            // Illegal opcode treated as NOP: just advance the PC
            pc_wr_out = 1'b1;
          end else begin
            case (w_op)
              LDI: begin
                sel_A_out  = SEL_A_IMM;
                acc_wr_out = 1'b1;
                pc_wr_out  = 1'b1;
              end
              ADDI, SUBI: begin
                sel_B_out     = 1'b1;
                alu_op_out    = (w_op == SUBI);
                sel_A_out     = SEL_A_ALU;
                acc_wr_out    = 1'b1;
                status_wr_out = 1'b1;
                pc_wr_out     = 1'b1;
              end
              LD, ADD, SUB, STO: begin
                dmem_req_out = 1'b1;
                if (dmem_ready_in) begin
                  pc_wr_out = 1'b1;
                  case (w_op)
                    LD: begin
                      sel_A_out  = SEL_A_MEM;
                      acc_wr_out = 1'b1;
                    end
                    ADD, SUB: begin
                      sel_B_out     = 1'b0;
                      alu_op_out    = (w_op == SUB);
                      sel_A_out     = SEL_A_ALU;
                      acc_wr_out    = 1'b1;
                      status_wr_out = 1'b1;
                    end
                    default: data_memory_wr_out = 1'b1;
                  endcase
                end
              end
              default: begin
                pc_wr_out  = 1'b1;
                branch_out = branch_taken(w_op, status_Z_in, status_N_in);
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign halted_out = (state_q == HALT);

  // Bus error is sticky until reset
  always_comb begin
    bus_error_d = bus_error_q || w_timeout;
  end

  // Bus error register
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      bus_error_q <= 1'b0;
    end else begin
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error_out = bus_error_q;

`ifdef DECODER_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic illegal_d;

  // Illegal flag latches on the decode of an out-of-range opcode
  always_comb begin
    illegal_d = illegal_q || ((state_q == DECODE) && !w_legal);
  end

  // Illegal flag register
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_out = illegal_q;
`else
  assign illegal_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_decoder.sv
// ============================================================================
// Module      : tb_multicycle_decoder
// Description : Self-checking bench for multicycle_decoder. Each instruction
//               is run with chosen wait states and summarised (latency, pulse
//               counts, mux values at the PC update) against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_decoder;

  localparam int C_TIMEOUT = 4;
  localparam int C_HLT = 0, C_LDI = 1, C_ADDI = 2, C_SUBI = 3, C_LD = 4, C_ADD = 5, C_SUB = 6,
                 C_STO = 7, C_BEQ = 8, C_BNE = 9, C_BGT = 10, C_BGE = 11, C_BLT = 12,
                 C_BLE = 13, C_JMP = 14;

  logic       clock_in = 1'b0;
  logic       reset_in = 1'b0;
  logic [4:0] op_code = 5'd0;
  logic       status_Z_in = 1'b0;
  logic       status_N_in = 1'b0;
  logic       imem_ready_in = 1'b0;
  logic       dmem_ready_in = 1'b0;
  logic       imem_req_out, dmem_req_out, ir_wr_out, acc_wr_out, pc_wr_out, status_wr_out;
  logic       data_memory_wr_out, branch_out, sel_B_out, alu_op_out;
  logic [1:0] sel_A_out;
  logic       acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out;
  logic       halted_out, bus_error_out, illegal_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         lat;
    int         ir_cnt;
    int         ir_cyc;
    int         ireq;
    int         dreq;
    int         acc;
    int         st;
    int         dwr;
    int         pc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu;
    logic       br;
    logic       halted;
  } stats_t;

  stats_t got;

  multicycle_decoder #(
    .OPCODE_WIDTH   (5),
    .TIMEOUT_CYCLES (C_TIMEOUT)
  ) dut (
    .clock_in           (clock_in),
    .reset_in           (reset_in),
    .op_code            (op_code),
    .status_Z_in        (status_Z_in),
    .status_N_in        (status_N_in),
    .imem_ready_in      (imem_ready_in),
    .dmem_ready_in      (dmem_ready_in),
    .imem_req_out       (imem_req_out),
    .dmem_req_out       (dmem_req_out),
    .ir_wr_out          (ir_wr_out),
    .acc_wr_out         (acc_wr_out),
    .pc_wr_out          (pc_wr_out),
    .status_wr_out      (status_wr_out),
    .data_memory_wr_out (data_memory_wr_out),
    .branch_out         (branch_out),
    .sel_A_out          (sel_A_out),
    .sel_B_out          (sel_B_out),
    .alu_op_out         (alu_op_out),
    .acc_reset_out      (acc_reset_out),
    .pc_reset_out       (pc_reset_out),
    .status_reset_out   (status_reset_out),
    .ir_reset_out       (ir_reset_out),
    .halted_out         (halted_out),
    .bus_error_out      (bus_error_out),
    .illegal_out        (illegal_out)
  );

  always #5 clock_in = ~clock_in;

  // Instruction-level reference: what one legal instruction should look like
  function automatic stats_t model(input int op, input bit z, input bit n, input int iw, input int dw);
    stats_t e;
    bit     mem;
    e = '{lat: 0, ir_cnt: 1, ir_cyc: iw, ireq: iw + 1, dreq: 0, acc: 0, st: 0, dwr: 0, pc: 1,
          sel_a: 2'b00, sel_b: 1'b0, alu: 1'b0, br: 1'b0, halted: 1'b0};
    mem    = (op == C_LD) || (op == C_ADD) || (op == C_SUB) || (op == C_STO);
    e.dreq = mem ? dw + 1 : 0;
    e.lat  = 3 + iw + (mem ? dw : 0);
    case (op)
      C_LDI:  begin e.acc = 1; e.sel_a = 2'b10; end
      C_ADDI: begin e.acc = 1; e.st = 1; e.sel_b = 1'b1; end
      C_SUBI: begin e.acc = 1; e.st = 1; e.sel_b = 1'b1; e.alu = 1'b1; end
      C_LD:   begin e.acc = 1; e.sel_a = 2'b01; end
      C_ADD:  begin e.acc = 1; e.st = 1; end
      C_SUB:  begin e.acc = 1; e.st = 1; e.alu = 1'b1; end
      C_STO:  e.dwr = 1;
      C_BEQ:  e.br = z;
      C_BNE:  e.br = !z;
      C_BGT:  e.br = !z && !n;
      C_BGE:  e.br = !n;
      C_BLT:  e.br = n;
      C_BLE:  e.br = z || n;
      C_JMP:  e.br = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Reset for one cycle; returns at a falling edge with the core in FETCH
  task automatic do_reset();
    @(negedge clock_in);
    reset_in      = 1'b1;
    imem_ready_in = 1'b0;
    dmem_ready_in = 1'b0;
    @(negedge clock_in);
    reset_in = 1'b0;
  endtask

  // Run one instruction from FETCH; memories answer after iw / dw wait cycles
  task automatic run_instr(input int op, input bit z, input bit n, input int iw, input int dw);
    int cyc;
    int ireq_n;
    int dreq_n;
    bit done;
    got = '{lat: 0, ir_cnt: 0, ir_cyc: -1, ireq: 0, dreq: 0, acc: 0, st: 0, dwr: 0, pc: 0,
            sel_a: 2'b00, sel_b: 1'b0, alu: 1'b0, br: 1'b0, halted: 1'b0};
    op_code     = 5'(op);
    status_Z_in = z;
    status_N_in = n;
    cyc = 0; ireq_n = 0; dreq_n = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      #1;
      imem_ready_in = imem_req_out && (ireq_n == iw);
      dmem_ready_in = dmem_req_out && (dreq_n == dw);
      #1;
      if (halted_out) begin
        got.halted = 1'b1;
        done       = 1'b1;
      end else begin
        if (imem_req_out) ireq_n++;
        if (dmem_req_out) dreq_n++;
        if (ir_wr_out) begin got.ir_cnt++; got.ir_cyc = cyc; end
        if (acc_wr_out) got.acc++;
        if (status_wr_out) got.st++;
        if (data_memory_wr_out) got.dwr++;
        if (pc_wr_out) begin
          got.pc++;
          got.sel_a = sel_A_out;
          got.sel_b = sel_B_out;
          got.alu   = alu_op_out;
          got.br    = branch_out;
          done      = 1'b1;
        end
        @(negedge clock_in);
        cyc++;
      end
    end
    got.lat  = cyc;
    got.ireq = ireq_n;
    got.dreq = dreq_n;
    imem_ready_in = 1'b0;
    dmem_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    op_code       = 5'($urandom_range(0, 31));
    status_Z_in   = 1'($urandom);
    status_N_in   = 1'($urandom);
    imem_ready_in = 1'b1;
    dmem_ready_in = 1'b1;
    #1 reset_in = 1'b1;
    repeat (2) @(negedge clock_in);
    #1;
    n_checks++;
    if ({acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out} !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 1111",
               {acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out});
    end
    n_checks++;
    if ({imem_req_out, dmem_req_out, ir_wr_out, acc_wr_out, pc_wr_out, status_wr_out,
         data_memory_wr_out, branch_out, sel_A_out, sel_B_out, alu_op_out} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_enables: got %b want 000000000000",
               {imem_req_out, dmem_req_out, ir_wr_out, acc_wr_out, pc_wr_out, status_wr_out,
                data_memory_wr_out, branch_out, sel_A_out, sel_B_out, alu_op_out});
    end
    n_checks++;
    if ({halted_out, bus_error_out, illegal_out} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {halted_out, bus_error_out, illegal_out});
    end
    imem_ready_in = 1'b0;
    dmem_ready_in = 1'b0;
    @(negedge clock_in);
    reset_in = 1'b0;
    #1;
    n_checks++;
    if (imem_req_out !== 1'b1 || acc_reset_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_fetch: got req=%b rst=%b want req=1 rst=0",
               imem_req_out, acc_reset_out);
    end
    @(negedge clock_in);
  endtask

  task automatic test_ldi();
    do_reset();
    run_instr(C_LDI, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (got.ir_cyc !== 0 || got.lat !== 3) begin
      n_fail++;
      $display("FAIL ldi_timing: got ir_cyc=%0d lat=%0d want ir_cyc=0 lat=3", got.ir_cyc, got.lat);
    end
    n_checks++;
    if (got.acc !== 1 || got.pc !== 1 || got.sel_a !== 2'b10) begin
      n_fail++;
      $display("FAIL ldi_enables: got acc=%0d pc=%0d sel_a=%b want 1 1 10", got.acc, got.pc, got.sel_a);
    end
    #1;
    n_checks++;
    if (imem_req_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ldi_next_fetch: got imem_req=%b want 1", imem_req_out);
    end
  endtask

  task automatic test_add_wait();
    do_reset();
    run_instr(C_ADD, 1'($urandom), 1'($urandom), 0, 3);
    n_checks++;
    if (got.dreq !== 4 || got.lat !== 6) begin
      n_fail++;
      $display("FAIL add_wait_req: got dreq=%0d lat=%0d want dreq=4 lat=6", got.dreq, got.lat);
    end
    n_checks++;
    if (got.acc !== 1 || got.st !== 1 || got.pc !== 1 || got.sel_a !== 2'b00 || got.sel_b !== 1'b0) begin
      n_fail++;
      $display("FAIL add_wait_enables: got acc=%0d st=%0d pc=%0d sel_a=%b sel_b=%b want 1 1 1 00 0",
               got.acc, got.st, got.pc, got.sel_a, got.sel_b);
    end
  endtask

  task automatic test_branches();
    do_reset();
    run_instr(C_BLE, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (got.br !== 1'b0 || got.pc !== 1) begin
      n_fail++;
      $display("FAIL ble_z0n0: got br=%b pc=%0d want br=0 pc=1", got.br, got.pc);
    end
    run_instr(C_BLE, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (got.br !== 1'b1) begin
      n_fail++;
      $display("FAIL ble_z1: got br=%b want 1", got.br);
    end
    run_instr(C_BGT, 1'b0, 1'b1, 0, 0);
    n_checks++;
    if (got.br !== 1'b0) begin
      n_fail++;
      $display("FAIL bgt_n1: got br=%b want 0", got.br);
    end
    for (int i = 0; i < 4; i++) begin
      run_instr(C_JMP, 1'(i), 1'(i >> 1), 0, 0);
      n_checks++;
      if (got.br !== 1'b1) begin
        n_fail++;
        $display("FAIL jmp_%0d: got br=%b want 1", i, got.br);
      end
    end
  endtask

  task automatic test_random();
    stats_t e;
    int     op;
    bit     z, n;
    int     iw, dw;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(1, 14));
      z  = 1'($urandom);
      n  = 1'($urandom);
      iw = int'($urandom_range(0, 3));
      dw = int'($urandom_range(0, 3));
      e  = model(op, z, n, iw, dw);
      run_instr(op, z, n, iw, dw);
      n_checks++;
      if (got.lat !== e.lat || got.ir_cyc !== e.ir_cyc || got.halted !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_timing[%0d] op=%0d: got lat=%0d ir_cyc=%0d halted=%b want lat=%0d ir_cyc=%0d halted=0",
                 k, op, got.lat, got.ir_cyc, got.halted, e.lat, e.ir_cyc);
      end
      n_checks++;
      if (got.dreq !== e.dreq || got.ireq !== e.ireq) begin
        n_fail++;
        $display("FAIL rnd_req[%0d] op=%0d: got ireq=%0d dreq=%0d want ireq=%0d dreq=%0d",
                 k, op, got.ireq, got.dreq, e.ireq, e.dreq);
      end
      n_checks++;
      if (got.acc !== e.acc || got.st !== e.st || got.dwr !== e.dwr || got.pc !== e.pc) begin
        n_fail++;
        $display("FAIL rnd_enables[%0d] op=%0d: got acc=%0d st=%0d dwr=%0d pc=%0d want %0d %0d %0d %0d",
                 k, op, got.acc, got.st, got.dwr, got.pc, e.acc, e.st, e.dwr, e.pc);
      end
      n_checks++;
      if (got.sel_a !== e.sel_a || got.sel_b !== e.sel_b || got.alu !== e.alu || got.br !== e.br) begin
        n_fail++;
        $display("FAIL rnd_muxes[%0d] op=%0d z=%b n=%b: got sel_a=%b sel_b=%b alu=%b br=%b want %b %b %b %b",
                 k, op, z, n, got.sel_a, got.sel_b, got.alu, got.br, e.sel_a, e.sel_b, e.alu, e.br);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(31, 1'b1, 1'b1, 0, 0);
`ifdef DECODER_ILLEGAL_TRAP_EN
    n_checks++;
    if (got.halted !== 1'b1 || got.pc !== 0 || illegal_out !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_trap: got halted=%b pc=%0d illegal=%b want 1 0 1", got.halted, got.pc, illegal_out);
    end
`else
    n_checks++;
    if (got.pc !== 1 || got.lat !== 3 || got.br !== 1'b0 || got.acc !== 0 || got.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_nop: got pc=%0d lat=%0d br=%b acc=%0d halted=%b want 1 3 0 0 0",
               got.pc, got.lat, got.br, got.acc, got.halted);
    end
    #1;
    n_checks++;
    if (imem_req_out !== 1'b1 || illegal_out !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_refetch: got imem_req=%b illegal=%b want 1 0", imem_req_out, illegal_out);
    end
`endif
  endtask

  task automatic test_reset_mid_sto();
    do_reset();
    op_code = 5'(C_STO);
    #1 imem_ready_in = 1'b1;
    @(negedge clock_in);
    imem_ready_in = 1'b0;
    @(negedge clock_in);
    #1;
    n_checks++;
    if (dmem_req_out !== 1'b1) begin
      n_fail++;
      $display("FAIL sto_dmem_req: got %b want 1", dmem_req_out);
    end
    dmem_ready_in = 1'b1;
    reset_in      = 1'b1;
    #1;
    n_checks++;
    if (data_memory_wr_out !== 1'b0 || dmem_req_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sto_reset_abort: got wr=%b req=%b want 0 0", data_memory_wr_out, dmem_req_out);
    end
    @(negedge clock_in);
    reset_in = 1'b0;
    #1;
    n_checks++;
    if (imem_req_out !== 1'b1 || data_memory_wr_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sto_reset_refetch: got imem_req=%b wr=%b want 1 0", imem_req_out, data_memory_wr_out);
    end
    dmem_ready_in = 1'b0;
  endtask

  task automatic test_imem_timeout();
    do_reset();
    run_instr(C_LDI, 1'b0, 1'b0, 1000, 0);
    n_checks++;
    if (got.ireq !== C_TIMEOUT || got.ir_cnt !== 0 || got.halted !== 1'b1) begin
      n_fail++;
      $display("FAIL imem_timeout: got ireq=%0d ir_wr=%0d halted=%b want %0d 0 1",
               got.ireq, got.ir_cnt, got.halted, C_TIMEOUT);
    end
    repeat (3) @(negedge clock_in);
    #1;
    n_checks++;
    if (bus_error_out !== 1'b1 || halted_out !== 1'b1 || imem_req_out !== 1'b0) begin
      n_fail++;
      $display("FAIL imem_timeout_sticky: got bus_err=%b halted=%b req=%b want 1 1 0",
               bus_error_out, halted_out, imem_req_out);
    end
  endtask

  task automatic test_dmem_timeout();
    do_reset();
    #1;
    n_checks++;
    if (bus_error_out !== 1'b0 || halted_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bus_error_cleared: got bus_err=%b halted=%b want 0 0", bus_error_out, halted_out);
    end
    run_instr(C_LD, 1'b0, 1'b0, 0, 1000);
    n_checks++;
    if (got.dreq !== C_TIMEOUT || got.acc !== 0 || got.pc !== 0 || got.halted !== 1'b1 || bus_error_out !== 1'b1) begin
      n_fail++;
      $display("FAIL dmem_timeout: got dreq=%0d acc=%0d pc=%0d halted=%b bus_err=%b want %0d 0 0 1 1",
               got.dreq, got.acc, got.pc, got.halted, bus_error_out, C_TIMEOUT);
    end
  endtask

  task automatic test_hlt();
    do_reset();
    run_instr(C_HLT, 1'b0, 1'b0, 1, 0);
    n_checks++;
    if (got.halted !== 1'b1 || got.pc !== 0 || got.lat !== 3 || bus_error_out !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt: got halted=%b pc=%0d lat=%0d bus_err=%b want 1 0 3 0",
               got.halted, got.pc, got.lat, bus_error_out);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add_wait();
    test_branches();
    test_random();
    test_illegal();
    test_reset_mid_sto();
    test_imem_timeout();
    test_dmem_timeout();
    test_hlt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
